// File: rtl/uart_rx_if.sv
// UART receiver bus: serial input plus the received-byte outputs.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    input  data, data_valid, frame_err, busy
  );

  modport slave (
    input  rx,
    output data, data_valid, frame_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver, 8N1, LSB first, with break-safe error recovery.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rx_s
// START     | timing to mid start bit to reject short low glitches
// DATA      | sampling eight data bits at bit centres
// STOP      | sampling the stop bit; reports byte or framing error
// WAIT_HIGH | stop bit was low; wait for line high before re-arming
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  localparam logic [7:0] HALF_TC = 8'(OVERSAMPLE / 2 - 1);
  localparam logic [7:0] FULL_TC = 8'(OVERSAMPLE - 1);

  logic       rx_meta_q, rx_meta_d;
  logic       rx_s_q, rx_s_d;
  logic [2:0] state_q, state_d;
  logic [7:0] tick_q, tick_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       data_valid_q, data_valid_d;
  logic       frame_err_q, frame_err_d;

  // Two-stage synchronizer for the asynchronous serial line.
  always_comb begin
    rx_meta_d = bus.rx;
    rx_s_d    = rx_meta_q;
  end

  // Receive FSM: tick counter times bit centres, shift register collects bits.
  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          tick_d  = 8'd0;
        end
      end
      S_START: begin
        if (tick_q == HALF_TC) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            tick_d    = 8'd0;
            bit_idx_d = 3'd0;
          end
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end
      S_DATA: begin
        if (tick_q == FULL_TC) begin
          shift_d[bit_idx_q] = rx_s_q;
          tick_d             = 8'd0;
          // Index parks at 7 instead of wrapping; START->DATA clears it.
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end
      S_STOP: begin
        if (tick_q == FULL_TC) begin
          tick_d = 8'd0;
          // Returning to IDLE at mid stop bit leaves half a bit of slack
          // to catch a start bit that follows immediately.
          if (rx_s_q) begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HIGH;
          end
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous reset; synchronizer resets to idle-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= S_IDLE;
      tick_q       <= 8'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      data_q       <= 8'd0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule
